// File: rtl/imm_gen_pkg.sv
// Shared types and helpers for the pipelined immediate generator.
// Helpers build at the widest supported XLEN; callers truncate to their own XLEN.
package imm_gen_pkg;

  localparam int unsigned XLEN_MAX = 64;

  typedef enum logic [3:0] {
    SEL_NONE   = 4'd0,
    SEL_I      = 4'd1,
    SEL_S      = 4'd2,
    SEL_B      = 4'd3,
    SEL_J      = 4'd4,
    SEL_U      = 4'd5,
    SEL_SHAMT  = 4'd6,
    SEL_ZIMM   = 4'd7,
    SEL_CI     = 4'd8,
    SEL_CJ     = 4'd9,
    SEL_CB     = 4'd10,
    SEL_RSV11  = 4'd11,
    SEL_RSV12  = 4'd12,
    SEL_RSV13  = 4'd13,
    SEL_RSV14  = 4'd14,
    SEL_RSV15  = 4'd15
  } imm_sel_t;

  // Field occupies v[w-1:0]; left-justify then arithmetic-shift back down.
  function automatic logic [XLEN_MAX-1:0] sext(input logic [31:0] v, input int unsigned w);
    logic signed [XLEN_MAX-1:0] t;
    t = $signed({v, 32'b0} << (32 - w));
    return $unsigned(t >>> (XLEN_MAX - w));
  endfunction

  function automatic logic [XLEN_MAX-1:0] zext(input logic [31:0] v, input int unsigned w);
    logic [XLEN_MAX-1:0] mask;
    mask = (64'd1 << w) - 64'd1;
    return {32'b0, v} & mask;
  endfunction

endpackage

// File: rtl/imm_gen_pipe_if.sv
// Handshake bus for imm_gen_pipe: input beat (instr/sel/tag) and output beat (imm/tag).
interface imm_gen_pipe_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic [3:0]       in_sel;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_imm;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_instr, in_sel, in_tag, out_ready,
    input  in_ready, out_valid, out_imm, out_tag
  );

  modport slave (
    input  in_valid, in_instr, in_sel, in_tag, out_ready,
    output in_ready, out_valid, out_imm, out_tag
  );
endinterface

// File: rtl/imm_gen_core.sv
// Combinational instruction/format-select to XLEN immediate decoder.
// Compressed formats (selects 8-10) exist only when IMM_GEN_PIPE_RVC_EN is defined.
module imm_gen_core
  import imm_gen_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0]     instr,
  input  imm_sel_t        sel,
  output logic [XLEN-1:0] imm
);

  always_comb begin
    imm = '0;
    case (sel)
      SEL_I:     imm = XLEN'(sext({20'b0, instr[31:20]}, 12));
      SEL_S:     imm = XLEN'(sext({20'b0, instr[31:25], instr[11:7]}, 12));
      SEL_B:     imm = XLEN'(sext({19'b0, instr[31], instr[7], instr[30:25],
                                   instr[11:8], 1'b0}, 13));
      SEL_J:     imm = XLEN'(sext({11'b0, instr[31], instr[19:12], instr[20],
                                   instr[30:21], 1'b0}, 21));
      SEL_U:     imm = XLEN'(sext({instr[31:12], 12'b0}, 32));
      SEL_SHAMT: imm = (XLEN == 64) ? XLEN'(zext({26'b0, instr[25:20]}, 6))
                                    : XLEN'(zext({27'b0, instr[24:20]}, 5));
      SEL_ZIMM:  imm = XLEN'(zext({27'b0, instr[19:15]}, 5));
`ifdef IMM_GEN_PIPE_RVC_EN
      SEL_CI:    imm = XLEN'(sext({26'b0, instr[12], instr[6:2]}, 6));
      SEL_CJ:    imm = XLEN'(sext({20'b0, instr[12], instr[8], instr[10:9], instr[6],
                                   instr[7], instr[2], instr[11], instr[5:3], 1'b0}, 12));
      SEL_CB:    imm = XLEN'(sext({23'b0, instr[12], instr[6:5], instr[2],
                                   instr[11:10], instr[4:3], 1'b0}, 9));
`endif
      default:   imm = '0;
    endcase
  end

`ifndef IMM_GEN_PIPE_RVC_EN
  // Opcode bits feed no 32-bit format; only the RVC decode reads them.
  logic unused_opcode;
  assign unused_opcode = ^instr[6:0];
`endif

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: latency-1 output register plus a one-entry skid
// so in_ready is a pure flop. Optional RVC decode: define IMM_GEN_PIPE_RVC_EN.
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  imm_gen_pipe_if.slave   bus
);

  logic [XLEN-1:0]  gen_imm;

  logic             out_valid_q, out_valid_d;
  logic [XLEN-1:0]  out_imm_q,   out_imm_d;
  logic [TAG_W-1:0] out_tag_q,   out_tag_d;
  logic             skid_valid_q, skid_valid_d;
  logic [XLEN-1:0]  skid_imm_q,   skid_imm_d;
  logic [TAG_W-1:0] skid_tag_q,   skid_tag_d;

  logic accept;
  logic xfer;

  imm_gen_core #(.XLEN(XLEN)) u_core (
    .instr (bus.in_instr),
    .sel   (imm_sel_t'(bus.in_sel)),
    .imm   (gen_imm)
  );

  assign accept = bus.in_valid && !skid_valid_q;
  assign xfer   = out_valid_q && bus.out_ready;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_imm_d    = out_imm_q;
    out_tag_d    = out_tag_q;
    skid_valid_d = skid_valid_q;
    skid_imm_d   = skid_imm_q;
    skid_tag_d   = skid_tag_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!out_valid_q || xfer) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_imm_d    = skid_imm_q;
        out_tag_d    = skid_tag_q;
        // accept is always 0 here while in_ready tracks !skid_valid; kept for FIFO safety.
        skid_valid_d = accept;
        if (accept) begin
          skid_imm_d = gen_imm;
          skid_tag_d = bus.in_tag;
        end
      end else begin
        out_valid_d = accept;
        if (accept) begin
          out_imm_d = gen_imm;
          out_tag_d = bus.in_tag;
        end
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_imm_d   = gen_imm;
      skid_tag_d   = bus.in_tag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_imm_q    <= '0;
      out_tag_q    <= '0;
      skid_valid_q <= 1'b0;
      skid_imm_q   <= '0;
      skid_tag_q   <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_imm_q    <= out_imm_d;
      out_tag_q    <= out_tag_d;
      skid_valid_q <= skid_valid_d;
      skid_imm_q   <= skid_imm_d;
      skid_tag_q   <= skid_tag_d;
    end
  end

  assign bus.in_ready  = !skid_valid_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_imm   = out_imm_q;
  assign bus.out_tag   = out_tag_q;

endmodule
